prog_counter_gen2: RTL and testbench
====================================

Name: prog_counter_gen2

Overview:
Parametrised up/down programmable counter. It generalises the 8-bit load/increment counter with the following features:
- configurable width
- decrement
- programmable terminal limit
- wrap or saturate mode
- step prescaler
- registered terminal-count pulse for cascading

It sits in the user-logic slot, driven from pin-level control bits, with a gated count output.

Parameters:
WIDTH, 8, counter/limit/load data width (>=2)
PRESCALE, 1, qualified step requests per actual count step (>=1; 1 = every request)
RESET_LIMIT, {WIDTH{1'b1}}, limit register value after reset

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
en  in  1  global enable; low freezes all state
load  in  1  load count from load_val
load_val  in  WIDTH  parallel load data
up  in  1  step request, increment
down  in  1  step request, decrement
limit_wr  in  1  write limit_val into limit register
limit_val  in  WIDTH  new terminal limit
sat_mode  in  1  0 = wrap at boundaries, 1 = saturate
out_enable  in  1  gate for count_o
count_o  out  WIDTH  out_enable ? count : 0 (combinational gate of register)
count_raw  out  WIDTH  count register, ungated
tc_o  out  1  one-cycle registered terminal-count pulse
at_zero  out  1  count == 0
at_limit  out  1  count >= limit

Behaviour:
- Reset:
  - Reset is asynchronous and active-high; while rst=1, all registers are held at reset values.
  - Reset values: count=0, limit=RESET_LIMIT, pre_cnt=0, tc_o=0.
  - Consequently at_zero=1 and count_o=0 during reset.
  - Reset asserted mid-step discards the step; no tc_o.
- en=0: count, limit and pre_cnt hold; load, limit_wr and step requests are ignored; tc_o=0 next cycle.
- Priority per cycle (en=1): load > step. limit_wr is independent of load and step.
- load=1: count <= load_val (no clamp); pre_cnt <= 0; tc_o <= 0. up/down are ignored that cycle.
- Step request: req = (up XOR down) & ~load. up=down=1 is a hold: no step, pre_cnt unchanged, no tc.
- Prescaler:
  - On req, if pre_cnt == PRESCALE-1, then step fires and pre_cnt <= 0; otherwise pre_cnt <= pre_cnt+1 and count holds.
  - The request direction is sampled on the firing cycle only.
  - For PRESCALE=1, pre_cnt is absent and every req fires.
- Up step:
  - count < limit: count+1.
  - count >= limit, wrap mode: count <= 0, tc_o pulses.
  - count >= limit, saturate mode: count holds, tc_o pulses.
- Down step:
  - count > 0: count-1.
  - count == 0, wrap mode: count <= limit, tc_o pulses.
  - count == 0, saturate mode: count holds, tc_o pulses.
- Boundary comparisons use the limit value registered before this cycle's limit_wr.
- A new limit takes effect on the next cycle. Lowering the limit below count leaves count unchanged; the next up step takes the boundary action.
- limit=0: up and down steps both hit a boundary; count stays 0 in both modes; tc_o pulses on every fired step.
- tc_o is registered: high for exactly the cycle after the boundary step; low otherwise. Back-to-back boundary steps give tc_o high on consecutive cycles.
- Latency:
  - count updates 1 cycle after the qualifying edge.
  - count_o, at_zero and at_limit are combinational from registers (0-cycle after count).
- Width arithmetic: all WIDTH bits, unsigned, no carry-out beyond tc_o.

Decomposition:
- Package prog_counter_pkg:
  - sat_mode encodings MODE_WRAP=1'b0, MODE_SAT=1'b1
  - a function computing the prescaler counter width, $clog2(PRESCALE) with a minimum of 1
- One sub-module counter_prescaler (params PRESCALE):
  - inputs clk, rst, en, clear (=load), req
  - output fire
  - owns pre_cnt

Test Plan:
- Reset/gate: rst=1 mid-count, then release; out_enable=0/1 -> count_raw=0; tc_o=0; at_zero=1; count_o=0 while out_enable=0; count_o=count_raw when out_enable=1.
- Wrap up, WIDTH=8, limit=5, sat_mode=0: load 3, then 3 up cycles -> 4, 5, 0; tc_o high exactly the cycle after count goes 5->0.
- Saturate down: load 1, sat_mode=1, 3 down cycles -> 0, 0, 0; tc_o pulses on the 2nd and 3rd cycles only; at_zero=1.
- Priority/simultaneous: load=1, up=1, load_val=0xA0 -> count=0xA0, no step. up=down=1 -> hold. en=0 with load=1 -> no change.
- Limit change: count=200, write limit=100 -> count stays 200, at_limit=1. Next up step in wrap mode -> 0 with tc_o. Down in wrap mode from 0 -> 100.
- PRESCALE=4: 8 consecutive up requests from 0 -> count steps only on the 4th and 8th (values 1, 2). load on the 2nd request clears pre_cnt, so 4 further requests are needed before the next step.

Source files
------------

// File: rtl/prog_counter_pkg.sv
// Shared encodings and sizing helpers for the programmable counter.
package prog_counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Width of the prescaler counter; never less than one bit.
  function automatic int pre_cnt_width(input int prescale);
    int w;
    w = $clog2(prescale);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/prog_counter_gen2_prescaler.sv
// Step prescaler: passes one in every PRESCALE qualified requests as a fire.
module counter_prescaler
  import prog_counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  input  logic req,
  output logic fire
);

  localparam int            PW   = pre_cnt_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic          last;

  // With PRESCALE=1 LAST is 0 and pre_cnt never leaves 0, so every request fires
  // and the register is a constant that synthesis removes.
  assign last = (pre_cnt_q == LAST);
  assign fire = en & req & ~clear & last;

  // Next prescaler count: load clears, each request advances or rolls over.
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (en) begin
      if (clear)
        pre_cnt_d = '0;
      else if (req)
        pre_cnt_d = last ? '0 : pre_cnt_q + PW'(1);
    end
  end

  // Prescaler count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pre_cnt_q <= '0;
    else     pre_cnt_q <= pre_cnt_d;
  end

endmodule

// File: rtl/prog_counter_gen2.sv
// Up/down programmable counter with terminal limit, wrap/saturate and prescaler.
module prog_counter_gen2
  import prog_counter_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               PRESCALE    = 1,
  parameter logic [WIDTH-1:0] RESET_LIMIT = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up,
  input  logic             down,
  input  logic             limit_wr,
  input  logic [WIDTH-1:0] limit_val,
  input  logic             sat_mode,
  input  logic             out_enable,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] count_raw,
  output logic             tc_o,
  output logic             at_zero,
  output logic             at_limit
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             tc_q, tc_d;
  logic             req, fire;

  // up and down together cancel; load always wins over a step.
  assign req = (up ^ down) & ~load;

  counter_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .clear (load),
    .req   (req),
    .fire  (fire)
  );

  // Next count/limit/tc; boundaries are judged against the limit held before this cycle's write.
  always_comb begin
    count_d = count_q;
    limit_d = limit_q;
    tc_d    = 1'b0;
    if (en) begin
      if (limit_wr)
        limit_d = limit_val;
      if (load) begin
        count_d = load_val;
      end else if (fire) begin
        if (up) begin
          if (count_q < limit_q) begin
            count_d = count_q + WIDTH'(1);
          end else begin
            tc_d = 1'b1;
            if (sat_mode == MODE_WRAP)
              count_d = '0;
          end
        end else begin
          if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
          end else begin
            tc_d = 1'b1;
            if (sat_mode == MODE_WRAP)
              count_d = limit_q;
          end
        end
      end
    end
  end

  // Counter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      limit_q <= RESET_LIMIT;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      limit_q <= limit_d;
      tc_q    <= tc_d;
    end
  end

  assign count_raw = count_q;
  assign count_o   = out_enable ? count_q : '0;
  assign tc_o      = tc_q;
  assign at_zero   = (count_q == '0);
  assign at_limit  = (count_q >= limit_q);

endmodule

// File: tb/tb_prog_counter_gen2.sv
// Bench for prog_counter_gen2: a PRESCALE=1 and a PRESCALE=4 instance share stimulus;
// an integer model predicts both, plus literal expectations on the directed sequence.
module tb_prog_counter_gen2;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         en, load, up, down, limit_wr, sat_mode, out_enable;
  logic [W-1:0] load_val, limit_val;

  logic [W-1:0] count_o [2];
  logic [W-1:0] count_raw [2];
  logic         tc_o [2], at_zero [2], at_limit [2];

  int n_pass  = 0;
  int n_total = 0;

  // Model state, indexed by instance (0: PRESCALE=1, 1: PRESCALE=4).
  int m_cnt [2] = '{0, 0};
  int m_lim [2] = '{255, 255};
  int m_pre [2] = '{0, 0};
  bit m_tc  [2] = '{0, 0};
  int m_ps  [2] = '{1, 4};

  always #5 clk = ~clk;

  prog_counter_gen2 #(.WIDTH(W), .PRESCALE(1)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .up(up), .down(down), .limit_wr(limit_wr), .limit_val(limit_val),
    .sat_mode(sat_mode), .out_enable(out_enable),
    .count_o(count_o[0]), .count_raw(count_raw[0]), .tc_o(tc_o[0]),
    .at_zero(at_zero[0]), .at_limit(at_limit[0])
  );

  prog_counter_gen2 #(.WIDTH(W), .PRESCALE(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .up(up), .down(down), .limit_wr(limit_wr), .limit_val(limit_val),
    .sat_mode(sat_mode), .out_enable(out_enable),
    .count_o(count_o[1]), .count_raw(count_raw[1]), .tc_o(tc_o[1]),
    .at_zero(at_zero[1]), .at_limit(at_limit[1])
  );

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // One clock of the counter rules for instance k, on plain integers.
  task automatic model_step(input int k);
    int  nc;
    bit  ntc;
    nc  = m_cnt[k];
    ntc = 0;
    if (en) begin
      if (load) begin
        nc = int'(load_val);
        m_pre[k] = 0;
      end else if (up != down) begin
        if (m_pre[k] + 1 < m_ps[k]) begin
          m_pre[k] = m_pre[k] + 1;
        end else begin
          m_pre[k] = 0;
          if (up) begin
            if (m_cnt[k] >= m_lim[k]) begin
              ntc = 1;
              nc  = sat_mode ? m_cnt[k] : 0;
            end else nc = m_cnt[k] + 1;
          end else begin
            if (m_cnt[k] == 0) begin
              ntc = 1;
              nc  = sat_mode ? 0 : m_lim[k];
            end else nc = m_cnt[k] - 1;
          end
        end
      end
      if (limit_wr) m_lim[k] = int'(limit_val);
    end
    m_cnt[k] = nc;
    m_tc[k]  = ntc;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_cnt[k] = 0; m_lim[k] = 255; m_pre[k] = 0; m_tc[k] = 0;
      end
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  // Compare both instances against the model on every falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      check($sformatf("model count_raw[%0d]", k), int'(count_raw[k]), m_cnt[k]);
      check($sformatf("model count_o[%0d]", k), int'(count_o[k]), out_enable ? m_cnt[k] : 0);
      check($sformatf("model tc_o[%0d]", k), int'(tc_o[k]), int'(m_tc[k]));
      check($sformatf("model at_zero[%0d]", k), int'(at_zero[k]), int'(m_cnt[k] == 0));
      check($sformatf("model at_limit[%0d]", k), int'(at_limit[k]), int'(m_cnt[k] >= m_lim[k]));
    end
  end

  // Drive one cycle of inputs shortly after a falling edge, return at the next falling edge.
  task automatic cyc(input bit e, input bit ld, input int lv, input bit u, input bit d,
                     input bit lw, input int lval);
    #1;
    en = e; load = ld; load_val = W'(lv); up = u; down = d;
    limit_wr = lw; limit_val = W'(lval);
    @(negedge clk);
  endtask

  int exp4 [8] = '{0, 0, 0, 1, 1, 1, 1, 2};

  initial begin
    rst = 1'b1;
    en = 1'b1; load = 1'b0; load_val = '0; up = 1'b1; down = 1'b0;
    limit_wr = 1'b0; limit_val = '0; sat_mode = 1'b0; out_enable = 1'b0;

    // Reset held with a step request pending.
    repeat (2) @(negedge clk);
    check("rst count_raw", int'(count_raw[0]), 0);
    check("rst at_zero", int'(at_zero[0]), 1);
    check("rst tc_o", int'(tc_o[0]), 0);
    check("rst count_o gated", int'(count_o[0]), 0);
    #1 out_enable = 1'b1;
    #1 check("rst count_o open", int'(count_o[0]), 0);
    rst = 1'b0;
    cyc(1, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 0, 0);
    check("count after 3 ups", int'(count_raw[0]), 3);
    check("count_o ungated", int'(count_o[0]), 3);
    // Asynchronous reset in the middle of a step.
    #3 rst = 1'b1;
    #1 check("async rst count", int'(count_raw[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 0, 0, 0, 0, 0, 0);
    check("after rst tc", int'(tc_o[0]), 0);

    // Wrap up with limit 5.
    cyc(1, 0, 0, 0, 0, 1, 5);
    cyc(1, 1, 3, 0, 0, 0, 0);
    check("wrap load 3", int'(count_raw[0]), 3);
    cyc(1, 0, 0, 1, 0, 0, 0);
    check("wrap up 4", int'(count_raw[0]), 4);
    cyc(1, 0, 0, 1, 0, 0, 0);
    check("wrap up 5", int'(count_raw[0]), 5);
    check("wrap at_limit", int'(at_limit[0]), 1);
    check("wrap tc before", int'(tc_o[0]), 0);
    cyc(1, 0, 0, 1, 0, 0, 0);
    check("wrap up 0", int'(count_raw[0]), 0);
    check("wrap tc pulse", int'(tc_o[0]), 1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    check("wrap tc drop", int'(tc_o[0]), 0);

    // Saturating down.
    sat_mode = 1'b1;
    cyc(1, 1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0, 0);
    check("sat down 0", int'(count_raw[0]), 0);
    check("sat tc 1st", int'(tc_o[0]), 0);
    cyc(1, 0, 0, 0, 1, 0, 0);
    check("sat tc 2nd", int'(tc_o[0]), 1);
    cyc(1, 0, 0, 0, 1, 0, 0);
    check("sat tc 3rd", int'(tc_o[0]), 1);
    check("sat at_zero", int'(at_zero[0]), 1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    check("sat tc idle", int'(tc_o[0]), 0);

    // Priority and holds.
    sat_mode = 1'b0;
    cyc(1, 1, 'hA0, 1, 0, 0, 0);
    check("load beats up", int'(count_raw[0]), 'hA0);
    check("load no tc", int'(tc_o[0]), 0);
    cyc(1, 0, 0, 1, 1, 0, 0);
    check("up+down hold", int'(count_raw[0]), 'hA0);
    check("up+down no tc", int'(tc_o[0]), 0);
    cyc(0, 1, 'h11, 0, 0, 1, 9);
    check("en=0 load ignored", int'(count_raw[0]), 'hA0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    check("en=0 step ignored", int'(count_raw[0]), 'hA0);
    check("en=0 limit kept", int'(at_limit[0]), 1);

    // Limit change below count.
    cyc(1, 1, 200, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 100);
    check("lim count kept", int'(count_raw[0]), 200);
    check("lim at_limit", int'(at_limit[0]), 1);
    cyc(1, 0, 0, 1, 0, 0, 0);
    check("lim up wraps", int'(count_raw[0]), 0);
    check("lim up tc", int'(tc_o[0]), 1);
    cyc(1, 0, 0, 0, 1, 0, 0);
    check("lim down to limit", int'(count_raw[0]), 100);
    check("lim down tc", int'(tc_o[0]), 1);

    // Boundary uses the limit held before a same-cycle write.
    cyc(1, 1, 7, 0, 0, 1, 10);
    cyc(1, 0, 0, 1, 0, 1, 7);
    check("old limit used", int'(count_raw[0]), 8);
    check("old limit no tc", int'(tc_o[0]), 0);
    check("new limit at_limit", int'(at_limit[0]), 1);

    // Zero limit: every step is a boundary.
    cyc(1, 1, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0, 0, 0);
    check("lim0 up count", int'(count_raw[0]), 0);
    check("lim0 up tc", int'(tc_o[0]), 1);
    cyc(1, 0, 0, 0, 1, 0, 0);
    check("lim0 down count", int'(count_raw[0]), 0);
    check("lim0 down tc", int'(tc_o[0]), 1);

    // Prescaler of 4.
    cyc(1, 1, 0, 0, 0, 1, 255);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 0, 1, 0, 0, 0);
      check($sformatf("pre4 up %0d", i + 1), int'(count_raw[1]), exp4[i]);
    end
    check("pre1 after 8 ups", int'(count_raw[0]), 8);
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 0, 0);
    cyc(1, 1, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 0, 0);
    check("pre4 load clears", int'(count_raw[1]), 0);
    cyc(1, 0, 0, 1, 0, 0, 0);
    check("pre4 step after clear", int'(count_raw[1]), 1);
    cyc(1, 0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
